flit_tx_port: RTL and testbench



---
 rtl/flit_tx_port.sv | 137 +++++++++++++
 tb/tb_flit_tx_port.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/flit_tx_port.sv
// Credit-based flit transmitter feeding one switch input port.
// Locks a VC per packet, tracks per-VC downstream credits, registers flits out with 1-cycle latency.
module flit_tx_port #(
    parameter int NUM_VCS     = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int CW          = $clog2(BUFFER_SIZE + 1),
    localparam int VW         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_flit,
    input  logic [VW-1:0]         in_vc,
    input  logic                  in_last,
    input  logic [NUM_VCS-1:0]    credit_granted,
    output logic [31:0]           out_flit,
    output logic [VW-1:0]         out_vc,
    output logic                  data_ready_out,
    output logic                  packet_sent,
    output logic [NUM_VCS*CW-1:0] credits,
    output logic                  credit_err
);

    typedef enum logic {
        HEAD = 1'b0,
        BODY = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [VW-1:0]   cur_vc_q, cur_vc_d;
    logic [VW-1:0]   sel_vc;
    logic [CW-1:0]   cred_q [NUM_VCS];
    logic [CW-1:0]   cred_d [NUM_VCS];
    logic            err_q, err_d;
    logic [31:0]     flit_q;
    logic [VW-1:0]   ovc_q;
    logic            drdy_q;
    logic            sent_q;
    logic            xfer;

    // Once a packet is under way its VC is locked; in_vc only matters on the head.
    always_comb begin
        sel_vc = (state_q == BODY) ? cur_vc_q : in_vc;
    end

    always_comb begin
        in_ready = 1'b0;
        for (int v = 0; v < NUM_VCS; v++) begin
            if (sel_vc == VW'(v)) begin
                in_ready = (cred_q[v] != '0);
            end
        end
    end

    assign xfer = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        cur_vc_d = cur_vc_q;
        if (xfer) begin
            case (state_q)
                HEAD: begin
                    if (!in_last) begin
                        state_d  = BODY;
                        cur_vc_d = sel_vc;
                    end
                end
                BODY: begin
                    if (in_last) begin
                        state_d = HEAD;
                    end
                end
                default: state_d = HEAD;
            endcase
        end
    end

    // A send and a grant on the same VC in one cycle cancel out.
    always_comb begin
        logic dec;
        dec   = 1'b0;
        err_d = err_q;
        for (int v = 0; v < NUM_VCS; v++) begin
            cred_d[v] = cred_q[v];
            dec       = xfer && (sel_vc == VW'(v));
            if (dec && !credit_granted[v]) begin
                cred_d[v] = cred_q[v] - CW'(1);
            end else if (!dec && credit_granted[v]) begin
                if (cred_q[v] == CW'(BUFFER_SIZE)) begin
                    err_d = 1'b1;
                end else begin
                    cred_d[v] = cred_q[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HEAD;
            cur_vc_q <= '0;
            err_q    <= 1'b0;
            flit_q   <= '0;
            ovc_q    <= '0;
            drdy_q   <= 1'b0;
            sent_q   <= 1'b0;
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_q[v] <= CW'(BUFFER_SIZE);
            end
        end else begin
            state_q  <= state_d;
            cur_vc_q <= cur_vc_d;
            err_q    <= err_d;
            drdy_q   <= xfer;
            sent_q   <= xfer && in_last;
            for (int v = 0; v < NUM_VCS; v++) begin
                cred_q[v] <= cred_d[v];
            end
            if (xfer) begin
                flit_q <= in_flit;
                ovc_q  <= sel_vc;
            end
        end
    end

    for (genvar g = 0; g < NUM_VCS; g++) begin : g_cred_out
        assign credits[g*CW +: CW] = cred_q[g];
    end

    assign out_flit       = flit_q;
    assign out_vc         = ovc_q;
    assign data_ready_out = drdy_q;
    assign packet_sent    = sent_q;
    assign credit_err     = err_q;

endmodule

// File: tb/tb_flit_tx_port.sv
// Directed bench for flit_tx_port (2 VCs, 4-flit buffers) with a credit/FSM model
// and a scoreboard of expected output flits.
module tb_flit_tx_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_flit;
    logic [0:0]  in_vc;
    logic        in_last;
    logic [1:0]  credit_granted;
    logic [31:0] out_flit;
    logic [0:0]  out_vc;
    logic        data_ready_out;
    logic        packet_sent;
    logic [5:0]  credits;
    logic        credit_err;

    flit_tx_port #(.NUM_VCS(2), .BUFFER_SIZE(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .in_vc(in_vc), .in_last(in_last), .credit_granted(credit_granted),
        .out_flit(out_flit), .out_vc(out_vc), .data_ready_out(data_ready_out),
        .packet_sent(packet_sent), .credits(credits), .credit_err(credit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] flit;
        logic        vc;
        logic        last;
    } exp_t;

    exp_t        sbq[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          mdl_cred[2];
    bit          mdl_body;
    bit          mdl_vc;
    bit          mdl_err;
    logic [31:0] last_flit;
    logic        last_vc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state();
        logic [5:0] exp_cred;
        exp_cred = {3'(mdl_cred[1]), 3'(mdl_cred[0])};
        chk("credits", credits, exp_cred);
        chk("credit_err", credit_err, mdl_err);
    endtask

    task automatic check_out(input bit x);
        exp_t e;
        chk("data_ready_out", data_ready_out, x);
        if (data_ready_out === 1'b1) begin
            n_vec++;
            assert (sbq.size() != 0) else begin
                n_err++;
                $error("FAIL sb_underflow observed=pulse expected=none");
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("out_flit", out_flit, e.flit);
                chk("out_vc", out_vc, e.vc);
                chk("packet_sent", packet_sent, e.last);
                last_flit = e.flit;
                last_vc   = e.vc;
            end
        end else begin
            chk("out_flit_hold", out_flit, last_flit);
            chk("out_vc_hold", out_vc, last_vc);
            chk("packet_sent_idle", packet_sent, 1'b0);
        end
        chk_state();
    endtask

    // One clock of stimulus; the model predicts acceptance and next credit/FSM state.
    task automatic cycle(input bit v, input logic [31:0] f, input bit vc, input bit last,
                         input logic [1:0] g);
        bit   sel, rdy, x, d;
        exp_t e;
        in_valid = v; in_flit = f; in_vc = vc; in_last = last; credit_granted = g;
        #1;
        sel = mdl_body ? mdl_vc : vc;
        rdy = (mdl_cred[sel] != 0);
        chk("in_ready", in_ready, rdy);
        x = v && rdy;
        if (x) begin
            e.flit = f; e.vc = sel; e.last = last;
            sbq.push_back(e);
        end
        for (int k = 0; k < 2; k++) begin
            d = x && (sel == k[0]);
            if (d && !g[k]) mdl_cred[k]--;
            else if (!d && g[k]) begin
                if (mdl_cred[k] == 4) mdl_err = 1'b1;
                else mdl_cred[k]++;
            end
        end
        if (x) begin
            if (!mdl_body && !last) begin
                mdl_body = 1'b1;
                mdl_vc   = sel;
            end else if (mdl_body && last) begin
                mdl_body = 1'b0;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; credit_granted = 2'b00;
        check_out(x);
    endtask

    task automatic rst_cycle(input bit v);
        rst = 1'b1; in_valid = v; credit_granted = 2'b00;
        in_flit = 32'hDEAD_0000; in_vc = 1'b1; in_last = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        mdl_cred[0] = 4; mdl_cred[1] = 4;
        mdl_body = 1'b0; mdl_vc = 1'b0; mdl_err = 1'b0;
        sbq.delete();
        last_flit = '0; last_vc = 1'b0;
        chk("rst_data_ready_out", data_ready_out, 1'b0);
        chk("rst_packet_sent", packet_sent, 1'b0);
        chk("rst_out_flit", out_flit, 32'h0);
        chk("rst_out_vc", out_vc, 1'b0);
        chk_state();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_flit = '0; in_vc = '0; in_last = 1'b0;
        credit_granted = 2'b00;
        rst_cycle(1'b0);
        rst_cycle(1'b0);
        cycle(0, 32'h0, 0, 0, 2'b00);
        cycle(0, 32'h0, 1, 0, 2'b00);

        // 3-flit packet on VC1, no grants.
        cycle(1, 32'hA100_0001, 1, 0, 2'b00);
        cycle(1, 32'hA100_0002, 1, 0, 2'b00);
        cycle(1, 32'hA100_0003, 1, 1, 2'b00);
        cycle(0, 32'h0, 0, 0, 2'b00);

        // 6-flit packet on VC0 stalls after 4; in_vc=1 during body must be ignored.
        for (int i = 0; i < 4; i++) cycle(1, 32'hB000_0000 + 32'(i), 0, 0, 2'b00);
        cycle(1, 32'hB000_0004, 1, 0, 2'b00);
        cycle(1, 32'hB000_0004, 1, 0, 2'b01);
        cycle(1, 32'hB000_0004, 1, 0, 2'b00);
        cycle(1, 32'hB000_0005, 0, 1, 2'b00);
        cycle(1, 32'hB000_0005, 0, 1, 2'b01);
        cycle(1, 32'hB000_0005, 0, 1, 2'b00);

        // Mid-packet in_vc change, then a head on VC1.
        for (int i = 0; i < 3; i++) cycle(0, 32'h0, 0, 0, 2'b01);
        cycle(1, 32'hC000_0000 ^ $urandom_range(255), 0, 0, 2'b00);
        cycle(1, 32'hC000_0100 ^ $urandom_range(255), 1, 0, 2'b00);
        cycle(1, 32'hC000_0200 ^ $urandom_range(255), 1, 1, 2'b00);
        cycle(1, 32'hC100_0000, 1, 1, 2'b00);

        // Same-cycle send and grant on VC0 with count 1.
        cycle(0, 32'h0, 0, 0, 2'b01);
        cycle(1, 32'hD000_0001, 0, 1, 2'b01);
        cycle(1, 32'hD000_0002, 0, 1, 2'b00);
        for (int i = 0; i < 4; i++) cycle(0, 32'h0, 0, 0, 2'b11);
        cycle(0, 32'h0, 0, 0, 2'b10);

        // Overflow at full credits sets a sticky error.
        cycle(0, 32'h0, 0, 0, 2'b11);
        cycle(0, 32'h0, 0, 0, 2'b00);
        cycle(1, 32'hE000_0001, 1, 1, 2'b10);

        // Reset mid-packet abandons it and clears the error.
        cycle(1, 32'hF000_0001, 1, 0, 2'b00);
        cycle(1, 32'hF000_0002, 1, 0, 2'b00);
        rst_cycle(1'b1);
        cycle(1, 32'hF100_0001, 0, 1, 2'b00);
        cycle(0, 32'h0, 0, 0, 2'b00);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
